// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding req/ack fetch at a time,
// and buffers returned words with their PCs in a small FIFO drained over valid/ready.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     inst_valid,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fpc_q, fpc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   count_next;
    logic               push, pop;

    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        pc_mem_q   [DEPTH];

    assign imem_req   = (state_q != StIdle);
    assign imem_addr  = addr_q;
    assign count      = count_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

    // Redirect suppresses both push and pop: the queue is being discarded anyway.
    assign push       = (state_q == StReq) && imem_ack && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        addr_d   = addr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_next;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fpc_d    = redirect_pc;
            unique case (state_q)
                StIdle: begin
                    state_d = StReq;
                    addr_d  = redirect_pc;
                end
                StReq, StDrop: begin
                    // A request still in flight must be retired before the new PC is issued.
                    if (imem_ack) begin
                        state_d = StReq;
                        addr_d  = redirect_pc;
                    end else begin
                        state_d = StDrop;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_next < DEPTH_CNT) begin
                        state_d = StReq;
                        addr_d  = fpc_q;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        fpc_d = fpc_q + 32'd4;
                        if (count_next < DEPTH_CNT) begin
                            addr_d = fpc_q + 32'd4;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (imem_ack) begin
                        state_d = StReq;
                        addr_d  = fpc_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            fpc_q    <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head outputs are masked by inst_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= addr_q;
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle datapath's instruction input. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered with their PCs in a small FIFO, and the datapath consumes them over a valid/ready interface. A redirect (branch or jump resolved by the datapath) flushes the queue and restarts fetch at a new PC, safely dropping any in-flight response.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  word address of current request; stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle; may arrive in the same cycle req rises, or later.
- imem_rdata  in  32  instruction word, valid only when imem_ack=1.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC, sampled when redirect=1.
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction (0 when empty).
- inst_pc  out  32  PC of head instruction (0 when empty).
- inst_ready  in  1  consumer accepts head this cycle.
- count  out  log2(DEPTH)+1  entries currently held.

## Operation
- Registers: fetch PC fpc, imem_addr, FSM state, circular FIFO (inst, pc) with rd/wr pointers and count.
- FSM states: IDLE (req=0), REQ (req=1, live request), DROP (req=1, stale request whose data is discarded).
- IDLE -> REQ when count_next < DEPTH; imem_addr <= fpc. Otherwise IDLE.
- REQ, imem_ack=1: push {imem_rdata, imem_addr}; fpc <= fpc+4; stay REQ with imem_addr <= fpc+4 if count_next < DEPTH, else IDLE.
- REQ, imem_ack=0: hold imem_addr, stay REQ.
- DROP: hold imem_addr until imem_ack=1, discard data, go to REQ with imem_addr <= fpc.
- Pop when inst_valid & inst_ready: advance rd pointer. count_next = count + push − pop; simultaneous push and pop leaves count unchanged.
- At most one outstanding request; a push therefore never occurs when the queue is full.
- Redirect has priority over everything: queue emptied (count=0, pointers reset), the pop is ignored, fpc <= redirect_pc.
  - IDLE or REQ with imem_ack=1: ack data discarded, next state REQ, imem_addr <= redirect_pc.
  - REQ with imem_ack=0: next state DROP (old address held).
  - DROP: fpc updated to latest redirect_pc; stay DROP, or go to REQ at redirect_pc if imem_ack=1 this cycle.
- fpc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: state IDLE, fpc=RESET_PC, imem_req=0, imem_addr=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0.
- Reset mid-operation aborts any request immediately (imem_req=0 asynchronously); no drop is performed after release.
- First edge after rst deasserts: IDLE->REQ; imem_req=1 the following cycle.
- Ack in cycle N -> entry visible (inst_valid=1) in cycle N+1 if queue was empty; combinational head path, no extra stage.
- Zero-wait memory (ack every cycle in REQ) sustains one instruction per cycle.
- Queue full: request issue stops after the ack that fills the queue; it resumes (IDLE->REQ) on the edge of the first pop.
- Outputs inst and inst_pc are functions of the registered FIFO state only; no combinational path from imem_rdata.

## Test plan
- Reset/start: rst low 2 cycles, then release; ack held 1 -> imem_addr sequence 0,4,8,...; inst_valid rises two cycles after release+1; inst_pc tracks 0,4,8.
- Backpressure: inst_ready=0, ack=1 -> count reaches 4, imem_req drops to 0; raise inst_ready one cycle -> exactly one new request at address 16.
- Slow memory: ack arrives 3 cycles after req -> imem_addr stable for all 3 cycles; one entry pushed per request.
- Redirect during wait: REQ at 0x20, no ack, redirect to 0x100 -> DROP holds 0x20 until ack, that data is discarded, next request is 0x100, and inst_pc of the first delivered entry is 0x100.
- Redirect with coincident ack and pop: queue has 2 entries, ack=1, inst_ready=1, redirect to 0x40 -> count=0 next cycle, next imem_addr is 0x40.
- Wrap/reset: RESET_PC=32'hFFFF_FFF8 -> addresses FFF8, FFFC, 0; assert rst mid-wait -> imem_req=0 immediately and count=0.
